// File: rtl/ring_sequence_monitor.sv
// Ring sequence monitor: encodes a one-hot right-rotating ring, checks each step, tracks lock and revolutions.
// Optional 8-bit saturating error counter port err_cnt is built when ERR_COUNT_EN is defined.
module ring_sequence_monitor #(
  parameter int N        = 8,
  parameter int LOCK_CNT = 4,
  parameter int RW       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         ring_in,
  input  logic                 sample_en,
  input  logic                 err_clr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 idx_vld,
  output logic                 locked,
  output logic                 err_onehot,
  output logic                 err_seq,
  output logic                 err_sticky,
  output logic                 rev_tick,
  output logic [RW-1:0]        rev_cnt
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0]           err_cnt
`endif
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t        state, state_nx;
  logic [3:0]    good_cnt, good_cnt_nx;
  logic [IW-1:0] idx_nx, exp_idx, in_idx;
  logic          hot, is_exp, err_any;
  logic          idx_vld_nx, err_onehot_nx, err_seq_nx, rev_tick_nx;
  logic [RW-1:0] rev_cnt_nx;

  function automatic logic is_onehot(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  function automatic logic [IW-1:0] encode(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) r = IW'(i);
    return r;
  endfunction

  // The ring rotates right, so index 0 is followed by N-1.
  assign hot     = is_onehot(ring_in);
  assign in_idx  = encode(ring_in);
  assign exp_idx = (idx == '0) ? IW'(N - 1) : idx - IW'(1);
  assign is_exp  = (in_idx == exp_idx);
  assign err_any = err_onehot_nx | err_seq_nx;

  always_comb begin
    state_nx      = state;
    good_cnt_nx   = good_cnt;
    idx_nx        = idx;
    rev_cnt_nx    = rev_cnt;
    idx_vld_nx    = 1'b0;
    err_onehot_nx = 1'b0;
    err_seq_nx    = 1'b0;
    rev_tick_nx   = 1'b0;
    if (sample_en) begin
      if (!hot) begin
        err_onehot_nx = 1'b1;
        good_cnt_nx   = '0;
        state_nx      = SEARCH;
      end else begin
        idx_vld_nx = 1'b1;
        idx_nx     = in_idx;
        case (state)
          SEARCH: begin
            good_cnt_nx = '0;
            state_nx    = ACQUIRE;
          end
          ACQUIRE: begin
            if (!is_exp) begin
              err_seq_nx  = 1'b1;
              good_cnt_nx = '0;
            end else if (good_cnt + 4'd1 == 4'(LOCK_CNT)) begin
              good_cnt_nx = '0;
              state_nx    = LOCKED;
            end else begin
              good_cnt_nx = good_cnt + 4'd1;
            end
          end
          LOCKED: begin
            if (!is_exp) begin
              err_seq_nx  = 1'b1;
              good_cnt_nx = '0;
              state_nx    = ACQUIRE;
            end else if (idx == '0) begin
              rev_tick_nx = 1'b1;
              rev_cnt_nx  = rev_cnt + RW'(1);
            end
          end
          default: state_nx = SEARCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      idx        <= '0;
      rev_cnt    <= '0;
      idx_vld    <= 1'b0;
      locked     <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_sticky <= 1'b0;
      rev_tick   <= 1'b0;
    end else begin
      state      <= state_nx;
      good_cnt   <= good_cnt_nx;
      idx        <= idx_nx;
      rev_cnt    <= rev_cnt_nx;
      idx_vld    <= idx_vld_nx;
      locked     <= (state_nx == LOCKED);
      err_onehot <= err_onehot_nx;
      err_seq    <= err_seq_nx;
      rev_tick   <= rev_tick_nx;
      // A fresh error outranks a simultaneous clear.
      if (err_any)      err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_any) begin
      if (err_clr)               err_cnt <= 8'd1;
      else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Randomized and directed bench for ring_sequence_monitor against a behavioural model.
// Covers err_cnt as well when ERR_COUNT_EN is defined.
module tb_ring_sequence_monitor;
  localparam int N        = 8;
  localparam int LOCK_CNT = 4;
  localparam int RW       = 16;
  localparam int IW       = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ring_in = '0;
  logic          sample_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [IW-1:0] idx;
  logic          idx_vld, locked, err_onehot, err_seq, err_sticky, rev_tick;
  logic [RW-1:0] rev_cnt;
`ifdef ERR_COUNT_EN
  logic [7:0]    err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ring_sequence_monitor #(.N(N), .LOCK_CNT(LOCK_CNT), .RW(RW)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .sample_en(sample_en), .err_clr(err_clr),
    .idx(idx), .idx_vld(idx_vld), .locked(locked), .err_onehot(err_onehot),
    .err_seq(err_seq), .err_sticky(err_sticky), .rev_tick(rev_tick), .rev_cnt(rev_cnt)
`ifdef ERR_COUNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a captured reference position, a count of consecutive good steps,
  // and lock once that count reaches LOCK_CNT.
  int m_idx, m_good, m_rev, m_errcnt;
  bit m_have_ref, m_lock, m_sticky;
  bit e_vld, e_oh, e_seq, e_tick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idx = 0; m_good = 0; m_rev = 0; m_errcnt = 0;
      m_have_ref = 0; m_lock = 0; m_sticky = 0;
      e_vld = 0; e_oh = 0; e_seq = 0; e_tick = 0;
    end else begin
      e_vld = 0; e_oh = 0; e_seq = 0; e_tick = 0;
      if (sample_en) begin
        if ($countones(ring_in) != 1) begin
          e_oh = 1; m_have_ref = 0; m_lock = 0; m_good = 0;
        end else begin
          int k;
          k = 0;
          for (int i = 0; i < N; i++) if (ring_in[i]) k = i;
          e_vld = 1;
          if (!m_have_ref) begin
            m_have_ref = 1; m_good = 0;
          end else if (k != (m_idx + N - 1) % N) begin
            e_seq = 1; m_lock = 0; m_good = 0;
          end else if (m_lock) begin
            if (m_idx == 0) begin
              e_tick = 1; m_rev = (m_rev + 1) % (1 << RW);
            end
          end else begin
            m_good++;
            if (m_good >= LOCK_CNT) begin m_lock = 1; m_good = 0; end
          end
          m_idx = k;
        end
      end
      if (e_oh || e_seq) begin
        m_sticky = 1;
        m_errcnt = err_clr ? 1 : (m_errcnt < 255 ? m_errcnt + 1 : 255);
      end else if (err_clr) begin
        m_sticky = 0; m_errcnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("idx", 32'(idx), 32'(m_idx));
      check("idx_vld", 32'(idx_vld), 32'(e_vld));
      check("locked", 32'(locked), 32'(m_lock));
      check("err_onehot", 32'(err_onehot), 32'(e_oh));
      check("err_seq", 32'(err_seq), 32'(e_seq));
      check("err_sticky", 32'(err_sticky), 32'(m_sticky));
      check("rev_tick", 32'(rev_tick), 32'(e_tick));
      check("rev_cnt", 32'(rev_cnt), 32'(m_rev));
`ifdef ERR_COUNT_EN
      check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
    end
  end

  task automatic feed(input logic [N-1:0] v, input logic en, input logic clr);
    @(negedge clk);
    ring_in = v; sample_en = en; err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    logic [N-1:0] v;
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_idx", 32'(idx), 0);
    check("rst_held_locked", 32'(locked), 0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rev_cnt", 32'(rev_cnt), 0);
    check("post_rst_sticky", 32'(err_sticky), 0);

    feed(8'h01, 1, 0); check("t2_idx0", 32'(idx), 0); check("t2_vld0", 32'(idx_vld), 1);
    feed(8'h80, 1, 0); check("t2_idx7", 32'(idx), 7);
    feed(8'h40, 1, 0); check("t2_idx6", 32'(idx), 6);
    feed(8'h20, 1, 0); check("t2_idx5", 32'(idx), 5); check("t2_not_locked", 32'(locked), 0);
    feed(8'h10, 1, 0); check("t2_idx4", 32'(idx), 4); check("t2_locked", 32'(locked), 1);

    feed(8'h08, 1, 0);
    feed(8'h04, 1, 0);
    feed(8'h02, 1, 0);
    feed(8'h01, 1, 0); check("t3_no_tick", 32'(rev_tick), 0);
    feed(8'h80, 1, 0); check("t3_tick", 32'(rev_tick), 1); check("t3_rev1", 32'(rev_cnt), 1);
    feed(8'h40, 1, 0); check("t3_tick_off", 32'(rev_tick), 0);
    feed(8'h20, 1, 0); check("t5_idx5", 32'(idx), 5);

    feed(8'h08, 1, 1);
    check("t5_err_seq", 32'(err_seq), 1); check("t5_idx3", 32'(idx), 3);
    check("t5_vld", 32'(idx_vld), 1); check("t5_unlocked", 32'(locked), 0);
    check("t5_sticky_wins", 32'(err_sticky), 1);
    feed(8'h00, 0, 1); check("t5_sticky_clr", 32'(err_sticky), 0);

    feed(8'h04, 1, 0);
    feed(8'h02, 1, 0);
    feed(8'h01, 1, 0);
    feed(8'h80, 1, 0); check("t4_relocked", 32'(locked), 1);
    feed(8'h03, 1, 0);
    check("t4_err_oh", 32'(err_onehot), 1); check("t4_sticky", 32'(err_sticky), 1);
    check("t4_unlocked", 32'(locked), 0); check("t4_no_seq", 32'(err_seq), 0);
    feed(8'h00, 1, 0); check("t4_err_oh_zero", 32'(err_onehot), 1);
    feed(8'h01, 0, 0); check("t6_hold_idx", 32'(idx), 7); check("t6_hold_vld", 32'(idx_vld), 0);

`ifdef ERR_COUNT_EN
    repeat (300) feed(8'h00, 1, 0);
    check("t6_errcnt_sat", 32'(err_cnt), 255);
    feed(8'h00, 0, 1); check("t6_errcnt_clr", 32'(err_cnt), 0);
`endif

    cur = 7;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 85) begin
        int s;
        s = $urandom_range(0, 99);
        if (s < 90) begin
          cur = (cur + N - 1) % N;
          v = N'(1) << cur;
        end else if (s < 95) begin
          cur = $urandom_range(0, N - 1);
          v = N'(1) << cur;
        end else begin
          v = N'($urandom);
        end
        feed(v, 1, ($urandom_range(0, 19) == 0));
      end else begin
        feed(N'($urandom), 0, ($urandom_range(0, 19) == 0));
      end
    end

    // Asynchronous reset asserted between edges must clear outputs immediately.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_idx", 32'(idx), 0);
    check("async_locked", 32'(locked), 0);
    check("async_rev_cnt", 32'(rev_cnt), 0);
    check("async_sticky", 32'(err_sticky), 0);
    @(negedge clk);
    rst = 1'b0;
    feed(8'h20, 1, 0);
    check("after_rst_capture", 32'(idx), 5); check("after_rst_no_seq", 32'(err_seq), 0);
    feed(8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
